// File: rtl/rq_to_s3.sv
`default_nettype none
// ============================================================================
// Module   : rq_to_s3
// Purpose  : Streaming Rq (q = 8192, 13-bit) to S3 (ternary, 2-bit) converter.
//            Each incoming coefficient is centred and reduced mod 3 on
//            acceptance and buffered. Once the whole polynomial is in, every
//            buffered coefficient has coefficient N-1 subtracted (mod 3),
//            which reduces the result mod (3, Phi_n), and is streamed out.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept an input beat (LOAD phase)
//   in_data    in   LANES x 13-bit coefficients, lane k at [13k+12:13k]
//   out_valid  out  output beat valid (EMIT phase)
//   out_ready  in   consumer accepts output beat
//   out_data   out  LANES x 2-bit S3 coefficients, lane k at [2k+1:2k]
//   out_last   out  final output beat of a polynomial
//   busy       out  first accepted input beat .. last output transfer
// ============================================================================
module rq_to_s3 #(
  parameter int N     = 701,
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*13-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*2-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int BEATS     = (N + LANES - 1) / LANES;
  localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST_LANE = (N - 1) % LANES;
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_wr_cnt;
  logic [CW-1:0]   r_rd_cnt;
  logic [1:0]      r_last;
  logic            r_busy;
  logic [1:0]      r_buf [BEATS][LANES];
  logic [1:0]      w_red [LANES];
  logic            w_load;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_wr_final;
  logic            w_rd_final;

  // Mod-3 of a 14-bit value by digit folding: 4^k == 1 (mod 3), so summing
  // base-4 digits preserves the residue. Three folds bring it to 0..4.
  function automatic logic [1:0] mod3_14(input logic [13:0] v);
    logic [4:0] a;
    logic [2:0] b;
    logic [2:0] c;
    a = '0;
    for (int i = 0; i < 7; i++) begin
      a = a + {3'b000, v[2*i +: 2]};
    end
    b = {1'b0, a[1:0]} + {1'b0, a[3:2]} + {2'b00, a[4]};
    c = {1'b0, b[1:0]} + {2'b00, b[2]};
    mod3_14 = (c >= 3'd3) ? 2'(c - 3'd3) : c[1:0];
  endfunction

  // (a - b) mod 3 for a, b in 0..2; the 2-bit wrap is harmless because the
  // true result of a + 3 - b is 1 or 2 when a < b.
  function automatic logic [1:0] sub3(input logic [1:0] a, input logic [1:0] b);
    sub3 = (a >= b) ? (a - b) : (a - b + 2'd3);
  endfunction

  // Adding the sign bit folds the centring in: -8192 == 1 (mod 3).
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane_red
      assign w_red[k] = mod3_14({1'b0, in_data[13*k +: 13]} + {13'd0, in_data[13*k+12]});
    end
  endgenerate

  assign w_load     = (r_state == S_LOAD);
  assign in_ready   = rst_n & w_load;
  assign out_valid  = ~w_load;
  assign busy       = r_busy;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_wr_final = (r_wr_cnt == C_LAST_BEAT);
  assign w_rd_final = (r_rd_cnt == C_LAST_BEAT);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_in_fire && w_wr_final)  w_state_nxt = S_EMIT;
      S_EMIT:  if (w_out_fire && w_rd_final) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Output beat: buffered residues minus the captured final coefficient.
  // Padding lanes of the final beat are forced to 0.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (r_state == S_EMIT) begin
      out_last = w_rd_final;
      for (int k = 0; k < LANES; k++) begin
        if (!(w_rd_final && (k > LAST_LANE))) begin
          out_data[2*k +: 2] = sub3(r_buf[r_rd_cnt][k], r_last);
        end
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_LOAD;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_last   <= 2'd0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fire) begin
        r_busy <= 1'b1;
        if (w_wr_final) begin
          r_wr_cnt <= '0;
          r_last   <= w_red[LAST_LANE];
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (w_out_fire) begin
        if (w_rd_final) begin
          r_rd_cnt <= '0;
          r_busy   <= 1'b0;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

  // Coefficient buffer; contents need no reset. Padding lanes are not written.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (!(w_wr_final && (k > LAST_LANE))) begin
          r_buf[r_wr_cnt][k] <= w_red[k];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rq_to_s3.md
Name: rq_to_s3

Overview:
- Streaming converter from Rq (q = 8192, 13-bit coefficients) to S3 (ternary coefficients, 2-bit encoded). This is the reverse of the lift path.
- Sits after the decryption multiply and before the message/S3 consumer.
- Each coefficient is centred to (-4096..4095) and reduced mod 3. After the whole polynomial has been received, the result is reduced mod (3, Phi_n): coefficient N-1 is subtracted from every coefficient.
- The full polynomial is buffered because coefficient N-1 arrives last.

Parameters:
- N, 701, number of polynomial coefficients.
- LANES, 1, coefficients per beat on both interfaces (1..13).
- BEATS, ceil(N/LANES), derived; beats per polynomial.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  LANES*13  coefficients; lane k at bits [13k+12:13k] is coefficient index beat*LANES+k.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts output beat.
- out_data  out  LANES*2  S3 coefficients; lane k at bits [2k+1:2k], values 0/1/2 only (3 never driven).
- out_last  out  1  high with the final output beat of a polynomial.
- busy  out  1  high from first accepted input beat until the last output beat is transferred.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values: in_ready=0 during reset then 1 in LOAD; out_valid=0, out_last=0, out_data=0, busy=0. Beat counters=0, captured last coefficient=0, FSM=LOAD. Buffer contents are don't-care.
- Per-coefficient reduction, applied at input acceptance: r = (x + x[12]) mod 3 over the unsigned 13-bit x.
  - Equivalent to the centred value mod 3, since -8192 ≡ 1 (mod 3).
  - Implement with a 14-bit add followed by a mod-3 reduction. No divider.
- Storage: r written into a BEATS x LANES x 2-bit register buffer at the write beat index.
- FSM LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: store the beat, increment wr_cnt, set busy.
  - The lane holding index N-1 (final beat, lane (N-1) mod LANES) is also captured into r_last.
  - Lanes with index >= N on the final beat are ignored.
  - When the final beat is accepted: wr_cnt resets to 0 and the FSM moves to EMIT on the next cycle.
- FSM EMIT:
  - in_ready=0. out_valid=1 starting the cycle after the last input acceptance, so latency from last input beat to first output beat is 1 cycle.
  - out_data lane = (buf[rd_cnt][k] + 2*r_last) mod 3, i.e. r_i - r_last.
  - Padding lanes (index >= N) are driven 0. Coefficient N-1 is always output 0.
  - out_data and out_last hold stable while out_valid & !out_ready.
  - On out_valid & out_ready: rd_cnt increments.
  - out_last=1 exactly when rd_cnt==BEATS-1.
  - On the final transfer: rd_cnt=0, busy=0, FSM returns to LOAD. in_ready=1 on the following cycle, so there is one bubble between polynomials.
- No overlap: input is stalled during EMIT.
- Reset asserted mid-LOAD or mid-EMIT: on the next edge all outputs return to reset values and the partial polynomial is discarded. No output beat is produced for it.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Throughput: one beat per cycle each direction with no backpressure. Full polynomial takes 2*BEATS+1 cycles.

Test Plan:
- All-zero input polynomial (N=701, LANES=1) -> 701 output beats all 0; out_last only on beat 700; first out_valid 1 cycle after beat 700 accepted.
- c[0]=8191, c[1]=4096, c[2]=4095, c[3]=1, c[4]=3, all others 0 -> outputs 2,2,0,1,0, rest 0 (r_last=0).
- c[700]=1, all others 0 -> outputs 2 for indices 0..699, and 0 for index 700. With c[700]=8191 instead -> 1 for 0..699, 0 for 700.
- Random polynomial with random in_valid gaps and out_ready toggling (~50%) -> output sequence matches the software poly_Rq_to_S3 model; out_data stable while stalled; exactly 701 transfers.
- LANES=4 (BEATS=176): random polynomial -> matches model; final beat lane 0 = index 700 = 0, lanes 1..3 = 0.
- rst_n low for 1 cycle after 300 input beats, then a full fresh polynomial -> no output for the aborted one; fresh polynomial output correct; busy=0 immediately after reset.
